// File: rtl/perf_pkg.sv
// Shared definitions for the stream performance monitor.
// Purpose: channel FSM state type and default sizing constants.
// Contents: perf_state_t, PERF_NUM_CH, PERF_CNT_W.
package perf_pkg;

  localparam int PERF_NUM_CH = 4;
  localparam int PERF_CNT_W  = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } perf_state_t;

endpackage

// File: rtl/perf_channel.sv
// Purpose: measures one valid/ready stream: transfer duration, beats, stall/starve cycles, transfer count.
// Latency: every output is registered; results of the cycle's handshake are visible one cycle later.
// Backpressure: passive observer, drives nothing back into the stream.
// Ports: clk, rst_n (sync, active-low), clear (sync), valid/ready/last (observed stream),
//        cycles/beats/stall_cycles/starve_cycles/transfers (saturating counters), busy, done, saturated.
module perf_channel
  import perf_pkg::*;
#(
  parameter int CNT_W = PERF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid,
  input  logic             ready,
  input  logic             last,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] beats,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] starve_cycles,
  output logic [CNT_W-1:0] transfers,
  output logic             busy,
  output logic             done,
  output logic             saturated
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  perf_state_t state;

  logic             hs;
  logic [CNT_W-1:0] cycles_inc;
  logic [CNT_W-1:0] beats_inc;
  logic [CNT_W-1:0] stall_inc;
  logic [CNT_W-1:0] starve_inc;
  logic [CNT_W-1:0] transfers_inc;
  logic             hit_max;

  // Saturating increment: a counter at its maximum stays there.
  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign hs            = valid & ready;
  assign cycles_inc    = inc_sat(cycles);
  assign beats_inc     = inc_sat(beats);
  assign stall_inc     = inc_sat(stall_cycles);
  assign starve_inc    = inc_sat(starve_cycles);
  assign transfers_inc = inc_sat(transfers);

  // Any counter that will be written this ACTIVE cycle landing on its maximum.
  assign hit_max = (cycles_inc == CNT_MAX)
                 | (hs && (beats_inc == CNT_MAX))
                 | (!hs && valid && (stall_inc == CNT_MAX))
                 | (!valid && (starve_inc == CNT_MAX))
                 | (hs && last && (transfers_inc == CNT_MAX));

  // busy is the state register itself, so it stays a registered output.
  assign busy = (state == ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state         <= IDLE;
      cycles        <= CNT_ZERO;
      beats         <= CNT_ZERO;
      stall_cycles  <= CNT_ZERO;
      starve_cycles <= CNT_ZERO;
      transfers     <= CNT_ZERO;
      done          <= 1'b0;
      saturated     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Without a handshake the previous transfer's results stay readable.
          if (hs) begin
            cycles        <= CNT_ONE;
            beats         <= CNT_ONE;
            stall_cycles  <= CNT_ZERO;
            starve_cycles <= CNT_ZERO;
            // A pinned transfer count keeps the channel flagged across starts.
            if (last) begin
              transfers <= transfers_inc;
              done      <= 1'b1;
              saturated <= (transfers_inc == CNT_MAX);
            end else begin
              state     <= ACTIVE;
              saturated <= (transfers == CNT_MAX);
            end
          end
        end
        ACTIVE: begin
          cycles <= cycles_inc;
          if (hs) begin
            beats <= beats_inc;
          end else if (valid) begin
            stall_cycles <= stall_inc;
          end else begin
            starve_cycles <= starve_inc;
          end
          if (hs && last) begin
            state     <= IDLE;
            transfers <= transfers_inc;
            done      <= 1'b1;
          end
          if (hit_max) begin
            saturated <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stream_perf_monitor.sv
// Purpose: array of independent per-channel stream performance monitors with packed counter outputs.
// Latency: one cycle from observed handshake to updated counters/flags; no input-to-output comb path.
// Backpressure: none, the monitor only observes valid/ready/last.
// Ports: clk, rst_n (sync, active-low), clear/valid/ready/last [NUM_CH], counters packed as
//        channel i at [i*CNT_W +: CNT_W], busy/done/saturated [NUM_CH].
module stream_perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_CH = PERF_NUM_CH,
  parameter int CNT_W  = PERF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       valid,
  input  logic [NUM_CH-1:0]       ready,
  input  logic [NUM_CH-1:0]       last,
  output logic [NUM_CH*CNT_W-1:0] cycles,
  output logic [NUM_CH*CNT_W-1:0] beats,
  output logic [NUM_CH*CNT_W-1:0] stall_cycles,
  output logic [NUM_CH*CNT_W-1:0] starve_cycles,
  output logic [NUM_CH*CNT_W-1:0] transfers,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       saturated
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear[i]),
      .valid        (valid[i]),
      .ready        (ready[i]),
      .last         (last[i]),
      .cycles       (cycles[i*CNT_W +: CNT_W]),
      .beats        (beats[i*CNT_W +: CNT_W]),
      .stall_cycles (stall_cycles[i*CNT_W +: CNT_W]),
      .starve_cycles(starve_cycles[i*CNT_W +: CNT_W]),
      .transfers    (transfers[i*CNT_W +: CNT_W]),
      .busy         (busy[i]),
      .done         (done[i]),
      .saturated    (saturated[i])
    );
  end

endmodule

// File: tb/tb_stream_perf_monitor.sv
// Bench for stream_perf_monitor: directed scenarios with literal expectations plus random traffic,
// all compared every cycle against a transfer-level reference model.
module tb_stream_perf_monitor;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int unsigned MAXV = 65535;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   clear, valid, ready, last;
  logic [NCH*W-1:0] cycles, beats, stall_cycles, starve_cycles, transfers;
  logic [NCH-1:0]   busy, done, saturated;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference state per channel.
  int unsigned m_cyc[NCH], m_beat[NCH], m_stall[NCH], m_starve[NCH], m_tr[NCH];
  bit          m_act[NCH], m_done[NCH];

  always #5 clk = ~clk;

  stream_perf_monitor #(.NUM_CH(NCH), .CNT_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .valid        (valid),
    .ready        (ready),
    .last         (last),
    .cycles       (cycles),
    .beats        (beats),
    .stall_cycles (stall_cycles),
    .starve_cycles(starve_cycles),
    .transfers    (transfers),
    .busy         (busy),
    .done         (done),
    .saturated    (saturated)
  );

  function automatic int unsigned s1(input int unsigned x);
    return (x >= MAXV) ? MAXV : x + 1;
  endfunction

  // Model: organised around handshakes and whether a transfer is open.
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      m_done[c] = 1'b0;
      if (!rst_n || clear[c]) begin
        m_cyc[c] = 0; m_beat[c] = 0; m_stall[c] = 0; m_starve[c] = 0; m_tr[c] = 0;
        m_act[c] = 1'b0;
      end else if (valid[c] && ready[c]) begin
        if (!m_act[c]) begin
          m_cyc[c] = 1; m_beat[c] = 1; m_stall[c] = 0; m_starve[c] = 0;
        end else begin
          m_cyc[c]  = s1(m_cyc[c]);
          m_beat[c] = s1(m_beat[c]);
        end
        if (last[c]) begin
          m_act[c]  = 1'b0;
          m_tr[c]   = s1(m_tr[c]);
          m_done[c] = 1'b1;
        end else begin
          m_act[c] = 1'b1;
        end
      end else if (m_act[c]) begin
        m_cyc[c] = s1(m_cyc[c]);
        if (valid[c]) m_stall[c] = s1(m_stall[c]);
        else          m_starve[c] = s1(m_starve[c]);
      end
    end
  end

  task automatic chkc(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s ch%0d @%0t: got %0d want %0d", nm, c, $time, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Single compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        bit exp_sat;
        // Counters only grow between starts, so a sticky flag equals "some counter is at max".
        exp_sat = (m_cyc[c] == MAXV) || (m_beat[c] == MAXV) || (m_stall[c] == MAXV) ||
                  (m_starve[c] == MAXV) || (m_tr[c] == MAXV);
        chkc("cycles",    c, 64'(cycles[c*W +: W]),        64'(m_cyc[c]));
        chkc("beats",     c, 64'(beats[c*W +: W]),         64'(m_beat[c]));
        chkc("stall",     c, 64'(stall_cycles[c*W +: W]),  64'(m_stall[c]));
        chkc("starve",    c, 64'(starve_cycles[c*W +: W]), 64'(m_starve[c]));
        chkc("transfers", c, 64'(transfers[c*W +: W]),     64'(m_tr[c]));
        chkc("busy",      c, 64'(busy[c]),                 64'(m_act[c]));
        chkc("done",      c, 64'(done[c]),                 64'(m_done[c]));
        chkc("saturated", c, 64'(saturated[c]),            64'(exp_sat));
      end
    end
  end

  // Apply inputs, then return at the falling edge after they were sampled.
  task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] r,
                      input logic [NCH-1:0] l, input logic [NCH-1:0] cl);
    valid = v; ready = r; last = l; clear = cl;
    @(negedge clk);
  endtask

  function automatic logic [63:0] fld(input logic [NCH*W-1:0] bus, input int c);
    return 64'(bus[c*W +: W]);
  endfunction

  initial begin
    logic [NCH-1:0] rv, rr, rl, rc;
    rst_n = 1'b0;
    step('0, '0, '0, '0);
    chk_en = 1'b1;
    step('1, '1, '1, '0);      // reset overrides stream activity
    lit("rst_cycles", 64'(cycles), 64'd0);
    lit("rst_transfers", 64'(transfers), 64'd0);
    lit("rst_flags", 64'({busy, done, saturated}), 64'd0);
    rst_n = 1'b1;

    // Single-beat transfer on ch0.
    step(4'b0001, 4'b0001, 4'b0001, '0);
    lit("sb_cycles", fld(cycles, 0), 64'd1);
    lit("sb_beats", fld(beats, 0), 64'd1);
    lit("sb_stall", fld(stall_cycles, 0), 64'd0);
    lit("sb_starve", fld(starve_cycles, 0), 64'd0);
    lit("sb_transfers", fld(transfers, 0), 64'd1);
    lit("sb_done", 64'(done[0]), 64'd1);
    lit("sb_busy", 64'(busy[0]), 64'd0);
    step('0, '0, '0, '0);
    lit("sb_done_clr", 64'(done[0]), 64'd0);

    // ch1: 4 beats with 2 stall and 1 starve cycle.
    step(4'b0010, 4'b0010, '0, '0);
    step(4'b0010, 4'b0000, '0, '0);
    step(4'b0010, 4'b0000, '0, '0);
    step(4'b0010, 4'b0010, '0, '0);
    step(4'b0000, 4'b0010, 4'b0010, '0);  // last without handshake is ignored
    lit("mb_busy_mid", 64'(busy[1]), 64'd1);
    step(4'b0010, 4'b0010, '0, '0);
    step(4'b0010, 4'b0010, 4'b0010, '0);
    lit("mb_cycles", fld(cycles, 1), 64'd7);
    lit("mb_beats", fld(beats, 1), 64'd4);
    lit("mb_stall", fld(stall_cycles, 1), 64'd2);
    lit("mb_starve", fld(starve_cycles, 1), 64'd1);
    lit("mb_done", 64'(done[1]), 64'd1);
    step('0, '0, '0, '0);
    lit("mb_done_once", 64'(done[1]), 64'd0);
    lit("mb_hold", fld(cycles, 1), 64'd7);

    // ch2 cleared mid-transfer together with a handshake; ch3 keeps counting.
    step(4'b1100, 4'b1100, '0, '0);
    repeat (4) step(4'b0100, 4'b0100, '0, '0);
    lit("cl_pre2", fld(cycles, 2), 64'd5);
    lit("cl_pre3", fld(cycles, 3), 64'd5);
    step(4'b0100, 4'b0100, 4'b0100, 4'b0100);
    lit("cl_cycles2", fld(cycles, 2), 64'd0);
    lit("cl_beats2", fld(beats, 2), 64'd0);
    lit("cl_flags2", 64'({busy[2], done[2], saturated[2]}), 64'd0);
    lit("cl_cycles3", fld(cycles, 3), 64'd6);
    lit("cl_starve3", fld(starve_cycles, 3), 64'd5);
    lit("cl_busy3", 64'(busy[3]), 64'd1);

    // All channels mid-transfer at cycles=10, then a one-cycle reset.
    step('0, '0, '0, '1);
    step('1, '1, '0, '0);
    repeat (9) step(NCH'($urandom), NCH'($urandom), '0, '0);
    for (int c = 0; c < NCH; c++) lit("pr_cycles10", fld(cycles, c), 64'd10);
    rst_n = 1'b0;
    step('1, '1, '1, '0);
    rst_n = 1'b1;
    lit("pr_cycles", 64'(cycles), 64'd0);
    lit("pr_flags", 64'({busy, done, saturated}), 64'd0);
    step('0, '1, '1, '0);
    lit("pr_last_novld", 64'({busy, done}), 64'd0);
    lit("pr_tr", 64'(transfers), 64'd0);

    // Random traffic with occasional clears and resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      for (int c = 0; c < NCH; c++) begin
        rv[c] = ($urandom_range(0, 3) != 0);
        rr[c] = ($urandom_range(0, 2) != 0);
        rl[c] = ($urandom_range(0, 3) == 0);
        rc[c] = ($urandom_range(0, 63) == 0);
      end
      step(rv, rr, rl, rc);
    end
    rst_n = 1'b1;

    // Counter saturation on ch0 with a 16-bit counter.
    step('0, '0, '0, '1);
    step(4'b0001, 4'b0001, '0, '0);
    repeat (70000) step('0, '0, '0, '0);
    lit("sat_cycles", fld(cycles, 0), 64'd65535);
    lit("sat_starve", fld(starve_cycles, 0), 64'd65535);
    lit("sat_flag", 64'(saturated[0]), 64'd1);
    step(4'b0001, 4'b0001, 4'b0001, '0);
    lit("sat_end_cycles", fld(cycles, 0), 64'd65535);
    lit("sat_end_flag", 64'(saturated[0]), 64'd1);
    lit("sat_end_done", 64'(done[0]), 64'd1);
    step(4'b0001, 4'b0001, 4'b0001, '0);
    lit("sat_new_cycles", fld(cycles, 0), 64'd1);
    lit("sat_new_flag", 64'(saturated[0]), 64'd0);
    lit("sat_new_tr", fld(transfers, 0), 64'd2);
    step('0, '0, '0, '0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
